rf_sb: RTL and testbench
========================

# rf_sb

Parametrised general-purpose register file with integrated write-back scoreboard, successor to the single-write, two-read 32×32 register file in the pipelined core. Provides NRD combinational read ports with same-cycle write-to-read bypass, one write-back port, and a per-register pending-write counter. The decode stage uses the counter to detect RAW hazards on operands and to stall issue when a destination register's outstanding-write count would overflow. Sits between decode/issue and write-back.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of registers (power of 2, ≥2); AW = clog2(NREG)
- NRD, 2, number of read ports (≥1)
- CW, 2, pending-counter width; max outstanding writes per register = 2^CW−1
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NRD*AW  read addresses; port k at bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- rd_busy  out  NRD  port k operand has an outstanding write not retiring this cycle
- wr_en  in  1  write-back valid
- wr_addr  in  AW  write-back destination
- wr_data  in  XLEN  write-back data
- iss_en  in  1  instruction issued with a destination register
- iss_addr  in  AW  destination of issued instruction
- iss_stall  out  1  iss_addr counter saturated; issue must be held
- flush  in  1  clear all pending counters (pipeline squash)
- sb_err  out  1  sticky: write-back to a register with zero pending count

## Operation
- Register 0 is hardwired to zero: writes ignored, issues ignored, counter always 0, rd_busy for address 0 always 0, iss_stall never asserted for address 0.
- Write: wr_en & wr_addr≠0 → r[wr_addr] ← wr_data at the edge. The data write happens regardless of flush or counter state.
- Read (combinational): if wr_en & wr_addr≠0 & rd_addr[k]==wr_addr, then rd_data[k]=wr_data (bypass); otherwise r[rd_addr[k]].
- Counter update per register a≠0, computed as inc = iss_en & iss_addr==a & ~iss_stall and dec = wr_en & wr_addr==a & cnt[a]≠0:
  - flush → cnt ← 0 (overrides inc/dec)
  - inc & dec → unchanged
  - inc only → +1
  - dec only → −1
- iss_stall = iss_en & iss_addr≠0 & cnt[iss_addr]==2^CW−1 & ~(wr_en & wr_addr==iss_addr). A same-cycle retire frees a slot. A stalled issue does not increment.
- rd_busy[k] = rd_addr[k]≠0 & cnt≠0 & ~(wr_en & wr_addr==rd_addr[k] & cnt==1). The last retiring write is bypassed, so that operand is not busy. An issue in the same cycle does not affect rd_busy.
- sb_err sets on wr_en & wr_addr≠0 & cnt[wr_addr]==0 & ~flush. It clears only on rst.

## Timing
- Reset (rst high at edge): all r[i]=0, all cnt=0, sb_err=0. Next cycle, every rd_data=0 (absent bypass), rd_busy=0, iss_stall=0.
- Read latency 0 (combinational). Write visible on rd_data through bypass in the same cycle, and from the array in the next cycle.
- Counter effects are visible on rd_busy/iss_stall in the cycle after the edge.
- rst asserted mid-operation wins over wr_en, iss_en and flush. All pending state is discarded.
- Multiple read ports addressing the same or different registers are independent. No port limits.

## Structure
- Package rf_pkg: default XLEN/NREG/NRD/CW localparams, and an AW helper function (clog2).
- Sub-module rf_pend_ctr: one CW-bit counter with inc/dec/flush/rst and sat/one flags. Instantiated NREG−1 times in a generate loop.
- Data array, bypass muxes and rd_busy logic stay in rf_sb.

## Test plan
- Reset then read all 32 addresses on both ports → all 0, rd_busy=00, sb_err=0.
- Write 0xDEADBEEF to r5 while rd_addr0=5 in the same cycle → rd_data0=0xDEADBEEF (bypass), and r5 reads back 0xDEADBEEF next cycle. Write 0x1234 to r0 → r0 still reads 0.
- Issue r7 three times (CW=2) → cnt=3; fourth iss_en to r7 → iss_stall=1, cnt stays 3. Fourth issue with a concurrent write-back to r7 → iss_stall=0, cnt stays 3.
- Issue r9 once, then write back r9=0x55 with rd_addr1=9 in the same cycle → rd_busy[1]=0, rd_data1=0x55. Next cycle cnt[9]=0.
- Issue r3 and r4 twice each, assert flush with a concurrent write to r3=0xAA → all rd_busy=0 next cycle, r3=0xAA, sb_err=0.
- Write-back r12 with cnt[12]=0 → sb_err=1 and stays 1 until rst. Assert rst during an issue → cnt[12]=0, sb_err=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the register file with write-back scoreboard.
package rf_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned NRD_DEF  = 2;
  localparam int unsigned CW_DEF   = 2;

  // Address width for a register count; never narrower than one bit.
  function automatic int unsigned rf_aw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_pend_ctr.sv
// Per-register outstanding write-back counter with saturation and last-write flags.
module rf_pend_ctr
  import rf_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          flush,
  output logic [CW-1:0] cnt,
  output logic          sat,
  output logic          one
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dec_eff;

  // A retire against an empty counter is an error elsewhere; never wrap here.
  assign dec_eff = dec && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (inc && !dec_eff) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!inc && dec_eff) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = &cnt_q;
  assign one = (cnt_q == CW'(1));

endmodule

// File: rtl/rf_sb.sv
// Multi-read, single-write register file with same-cycle bypass and a pending-write
// scoreboard used by decode for RAW hazard detection and issue throttling.
module rf_sb
  import rf_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = NRD_DEF,
  parameter int unsigned CW   = CW_DEF,
  localparam int unsigned AW  = rf_aw(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_stall,
  input  logic              flush,
  output logic              sb_err
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [CW-1:0]   cnt    [NREG];
  logic            sat    [NREG];
  logic            one    [NREG];
  logic            wr_live;
  logic            sb_err_q;

  assign wr_live = wr_en && (wr_addr != '0);

  // Register 0 never stores data and never tracks writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign cnt[0] = '0;
  assign sat[0] = 1'b0;
  assign one[0] = 1'b0;

  for (genvar a = 1; a < int'(NREG); a++) begin : g_ctr
    logic inc, dec;
    assign inc = iss_en && (iss_addr == AW'(a)) && !iss_stall;
    assign dec = wr_en && (wr_addr == AW'(a));

    rf_pend_ctr #(
      .CW (CW)
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc),
      .dec   (dec),
      .flush (flush),
      .cnt   (cnt[a]),
      .sat   (sat[a]),
      .one   (one[a])
    );
  end

  // A retiring write to the saturated destination frees the slot it would need.
  assign iss_stall = iss_en && (iss_addr != '0) && sat[iss_addr] &&
                     !(wr_en && (wr_addr == iss_addr));

  always_comb begin
    logic [AW-1:0] addr;
    addr    = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      addr = rd_addr[k*AW +: AW];
      rd_data[k*XLEN +: XLEN] = (wr_live && (addr == wr_addr)) ? wr_data : regs_q[addr];
      // The final outstanding write retiring now is bypassed, so not a hazard.
      rd_busy[k] = (addr != '0) && (cnt[addr] != '0) &&
                   !(wr_en && (wr_addr == addr) && one[addr]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_q <= 1'b0;
    end else if (wr_live && (cnt[wr_addr] == '0) && !flush) begin
      sb_err_q <= 1'b1;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_rf_sb.sv
// Directed self-checking bench for rf_sb with the default 32x32, two-read, CW=2 setup.
module tb_rf_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [2*AW-1:0]   rd_addr;
  logic [2*XLEN-1:0] rd_data;
  logic [1:0]        rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              iss_stall;
  logic              flush;
  logic              sb_err;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  rf_sb u_dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_stall (iss_stall),
    .flush     (flush),
    .sb_err    (sb_err)
  );

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 32; a++) begin
      rd(AW'(a), AW'(31 - a));
      #1;
      n_total++;
      if (rd_data !== 64'h0) $display("FAIL reset_rd a=%0d got %h exp 0", a, rd_data);
      else n_pass++;
      n_total++;
      if (rd_busy !== 2'b00) $display("FAIL reset_busy a=%0d got %b exp 00", a, rd_busy);
      else n_pass++;
    end
    n_total++;
    if (sb_err !== 1'b0) $display("FAIL reset_sb_err got %b exp 0", sb_err);
    else n_pass++;
    n_total++;
    if (iss_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", iss_stall);
    else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    // Write to r0 is dropped and must not flag an error.
    rd(5'd0, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    #1;
    n_total++;
    if (rd_data[31:0] !== 32'h0) $display("FAIL r0_bypass got %h exp 0", rd_data[31:0]);
    else n_pass++;
    tick();
    wr_en = 1'b0;
    #1;
    n_total++;
    if (rd_data[31:0] !== 32'h0) $display("FAIL r0_read got %h exp 0", rd_data[31:0]);
    else n_pass++;
    n_total++;
    if (sb_err !== 1'b0) $display("FAIL r0_sb_err got %b exp 0", sb_err);
    else n_pass++;

    rd(5'd5, 5'd6);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    #1;
    n_total++;
    if (rd_data !== {32'h0, 32'hDEADBEEF}) $display("FAIL bypass got %h exp 00000000deadbeef", rd_data);
    else n_pass++;
    tick();
    wr_en = 1'b0;
    rd(5'd5, 5'd5);
    #1;
    n_total++;
    if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) $display("FAIL array_read got %h exp deadbeefdeadbeef", rd_data);
    else n_pass++;
    // Unscoreboarded write-back is flagged.
    n_total++;
    if (sb_err !== 1'b1) $display("FAIL bypass_sb_err got %b exp 1", sb_err);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    rd(5'd7, 5'd0);
    for (int i = 0; i < 3; i++) begin
      iss_en = 1'b1; iss_addr = 5'd7;
      #1;
      n_total++;
      if (iss_stall !== 1'b0) $display("FAIL stall_fill i=%0d got %b exp 0", i, iss_stall);
      else n_pass++;
      tick();
    end
    #1;
    n_total++;
    if (iss_stall !== 1'b1) $display("FAIL stall_sat got %b exp 1", iss_stall);
    else n_pass++;
    tick();
    n_total++;
    if (iss_stall !== 1'b1) $display("FAIL stall_held got %b exp 1", iss_stall);
    else n_pass++;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
    #1;
    n_total++;
    if (iss_stall !== 1'b0) $display("FAIL stall_freed got %b exp 0", iss_stall);
    else n_pass++;
    tick();
    wr_en = 1'b0;
    #1;
    // Issue and retire together leave the count at 3.
    n_total++;
    if (iss_stall !== 1'b1) $display("FAIL stall_still_sat got %b exp 1", iss_stall);
    else n_pass++;
    iss_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h70 + i;
      #1;
      n_total++;
      if (rd_busy[0] !== (i < 2)) $display("FAIL drain_busy i=%0d got %b exp %b", i, rd_busy[0], i < 2);
      else n_pass++;
      tick();
    end
    wr_en = 1'b0;
    #1;
    n_total++;
    if (rd_busy[0] !== 1'b0) $display("FAIL drained_busy got %b exp 0", rd_busy[0]);
    else n_pass++;
    n_total++;
    if (sb_err !== 1'b0) $display("FAIL stall_sb_err got %b exp 0", sb_err);
    else n_pass++;
  endtask

  task automatic test_retire();
    do_reset();
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    rd(5'd10, 5'd9);
    iss_en = 1'b0;
    #1;
    n_total++;
    if (rd_busy !== 2'b10) $display("FAIL retire_pending got %b exp 10", rd_busy);
    else n_pass++;
    // Same-cycle issue to r10 must not make port 0 busy yet.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    iss_en = 1'b1; iss_addr = 5'd10;
    #1;
    n_total++;
    if (rd_busy !== 2'b00) $display("FAIL retire_busy got %b exp 00", rd_busy);
    else n_pass++;
    n_total++;
    if (rd_data[63:32] !== 32'h55) $display("FAIL retire_bypass got %h exp 55", rd_data[63:32]);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if (rd_busy !== 2'b01) $display("FAIL retire_after got %b exp 01", rd_busy);
    else n_pass++;
    n_total++;
    if (rd_data[63:32] !== 32'h55) $display("FAIL retire_array got %h exp 55", rd_data[63:32]);
    else n_pass++;
    n_total++;
    if (sb_err !== 1'b0) $display("FAIL retire_sb_err got %b exp 0", sb_err);
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      iss_en = 1'b1; iss_addr = (i < 2) ? 5'd3 : 5'd4;
      tick();
    end
    iss_en = 1'b0;
    rd(5'd3, 5'd4);
    #1;
    n_total++;
    if (rd_busy !== 2'b11) $display("FAIL flush_pre got %b exp 11", rd_busy);
    else n_pass++;
    flush = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    #1;
    n_total++;
    if (rd_busy !== 2'b00) $display("FAIL flush_busy got %b exp 00", rd_busy);
    else n_pass++;
    n_total++;
    if (rd_data[31:0] !== 32'hAA) $display("FAIL flush_data got %h exp aa", rd_data[31:0]);
    else n_pass++;
    // Write-back to an idle register during flush is not an error.
    flush = 1'b1; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
    tick();
    idle();
    #1;
    n_total++;
    if (sb_err !== 1'b0) $display("FAIL flush_sb_err got %b exp 0", sb_err);
    else n_pass++;
  endtask

  task automatic test_sb_err();
    do_reset();
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hC;
    tick();
    wr_en = 1'b0;
    #1;
    n_total++;
    if (sb_err !== 1'b1) $display("FAIL sb_err_set got %b exp 1", sb_err);
    else n_pass++;
    iss_en = 1'b1; iss_addr = 5'd12;
    tick();
    tick();
    iss_en = 1'b0;
    rd(5'd12, 5'd12);
    #1;
    n_total++;
    if (sb_err !== 1'b1) $display("FAIL sb_err_sticky got %b exp 1", sb_err);
    else n_pass++;
    n_total++;
    if (rd_busy !== 2'b11) $display("FAIL sb_err_busy got %b exp 11", rd_busy);
    else n_pass++;
    // Reset overrides a concurrent issue.
    rst = 1'b1; iss_en = 1'b1; iss_addr = 5'd12;
    tick();
    idle();
    #1;
    n_total++;
    if (rd_busy !== 2'b00) $display("FAIL rst_busy got %b exp 00", rd_busy);
    else n_pass++;
    n_total++;
    if (sb_err !== 1'b0) $display("FAIL rst_sb_err got %b exp 0", sb_err);
    else n_pass++;
    n_total++;
    if (rd_data !== 64'h0) $display("FAIL rst_data got %h exp 0", rd_data);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0; rd_addr = '0;
    test_reset();
    test_bypass();
    test_stall();
    test_retire();
    test_flush();
    test_sb_err();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
